// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Purpose  : Pipelined MIPS control unit. Decodes the ID-stage opcode/func
//            into a control bundle and destination index, then carries the
//            bundle through the ID/EX, EX/MEM and MEM/WB registers. Detects
//            load-use hazards (stall + bubble) and applies branch flushes.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            opcode_id, func_id       - ID-stage instruction fields
//            rs_id, rt_id, rd_id      - ID-stage register indices
//            flush_ex                 - branch taken in EX, kill ID instr
//            jmp_id, illegal_id       - combinational decode results
//            stall_o                  - hold PC and IF/ID, bubble into EX
//            ex_*, mem_*, wb_*        - per-stage registered control/dst
//            stall_count              - saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int ALUOP_W     = 4,
  parameter bit LOADUSE_EN  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode_id,
  input  logic [5:0]             func_id,
  input  logic [REG_AW-1:0]      rs_id,
  input  logic [REG_AW-1:0]      rt_id,
  input  logic [REG_AW-1:0]      rd_id,
  input  logic                   flush_ex,
  output logic [1:0]             jmp_id,
  output logic                   illegal_id,
  output logic                   stall_o,
  output logic [ALUOP_W-1:0]     ex_alu_op,
  output logic                   ex_alu_src,
  output logic                   ex_alu_src1,
  output logic                   ex_branch,
  output logic                   ex_nbranch,
  output logic                   ex_data_c,
  output logic                   ex_mem_read,
  output logic                   ex_reg_write,
  output logic [REG_AW-1:0]      ex_dst,
  output logic                   mem_mem_read,
  output logic                   mem_mem_write,
  output logic                   mem_mem_to_reg,
  output logic                   mem_data_c,
  output logic                   mem_reg_write,
  output logic [REG_AW-1:0]      mem_dst,
  output logic                   wb_mem_to_reg,
  output logic                   wb_data_c,
  output logic                   wb_reg_write,
  output logic [REG_AW-1:0]      wb_dst,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [REG_AW-1:0] C_LINK_REG = {REG_AW{1'b1}};

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               alu_src1;
    logic               branch;
    logic               nbranch;
    logic               data_c;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic [REG_AW-1:0]  dst;
  } ex_bundle_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              data_c;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } mem_bundle_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              data_c;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } wb_bundle_t;

  ex_bundle_t  w_dec, ex_d, ex_q;
  mem_bundle_t mem_d, mem_q;
  wb_bundle_t  wb_d, wb_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  logic [3:0] w_op4;
  logic [1:0] w_jmp;
  logic       w_illegal;
  logic       w_link;
  logic       w_is_r;
  logic       w_hazard;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_dec     = '0;
    w_op4     = 4'b0000;
    w_jmp     = 2'b00;
    w_illegal = 1'b0;
    w_link    = 1'b0;
    w_is_r    = 1'b0;
    case (opcode_id)
      6'b000000: begin
        w_is_r = 1'b1;
        case (func_id)
          6'b010000: w_jmp = 2'b10;
          6'b010001: begin
            w_jmp           = 2'b10;
            w_dec.reg_write = 1'b1;
            w_dec.data_c    = 1'b1;
            w_link          = 1'b1;
          end
          6'b001011: begin w_dec.reg_write = 1'b1; w_op4 = 4'b1000; end
          6'b001100: begin w_dec.reg_write = 1'b1; w_op4 = 4'b1001; end
          6'b001101: begin w_dec.reg_write = 1'b1; w_op4 = 4'b1010; end
          default: begin
            // Remaining R-type ops pass func[3:0] straight to the ALU;
            // func[3:2]==10 are the shift forms that take shamt.
            w_dec.reg_write = 1'b1;
            w_op4           = func_id[3:0];
            w_dec.alu_src1  = (func_id[3:2] == 2'b10);
          end
        endcase
      end
      6'b001000: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b0000; end
      6'b001010: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b0101; end
      6'b010111: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
      end
      6'b101011: begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
      6'b000100: begin w_op4 = 4'b0001; w_dec.branch  = 1'b1; end
      6'b000101: begin w_op4 = 4'b0001; w_dec.nbranch = 1'b1; end
      6'b000010: w_jmp = 2'b01;
      6'b000011: begin
        w_jmp           = 2'b01;
        w_dec.reg_write = 1'b1;
        w_dec.data_c    = 1'b1;
        w_link          = 1'b1;
      end
      6'b000001: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b0011; end
      6'b001101: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b0100; end
      6'b001111: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b0111; end
      6'b000111: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_op4 = 4'b1111; end
      default:   w_illegal = 1'b1;
    endcase
    w_dec.alu_op = ALUOP_W'(w_op4);
    // Illegal instructions carry an all-zero bundle, destination included.
    if (w_illegal)   w_dec.dst = '0;
    else if (w_link) w_dec.dst = C_LINK_REG;
    else if (w_is_r) w_dec.dst = rd_id;
    else             w_dec.dst = rt_id;
  end

  assign jmp_id     = w_jmp;
  assign illegal_id = w_illegal;

  // --------------------------------------------------------------------------
  // Load-use hazard: rs/rt compared even if unused by the ID instruction.
  // --------------------------------------------------------------------------
  if (LOADUSE_EN) begin : g_loaduse_on
    assign w_hazard = ex_q.mem_read && (ex_q.dst != '0) &&
                      ((ex_q.dst == rs_id) || (ex_q.dst == rt_id));
  end else begin : g_loaduse_off
    assign w_hazard = 1'b0;
  end

  // A flush kills the dependent instruction anyway, so it overrides the stall.
  assign stall_o = w_hazard && !flush_ex;

  // --------------------------------------------------------------------------
  // Stage next-state
  // --------------------------------------------------------------------------
  always_comb begin
    ex_d  = (flush_ex || stall_o) ? '0 : w_dec;
    mem_d = '{mem_read:   ex_q.mem_read,
              mem_write:  ex_q.mem_write,
              mem_to_reg: ex_q.mem_to_reg,
              data_c:     ex_q.data_c,
              reg_write:  ex_q.reg_write,
              dst:        ex_q.dst};
    wb_d  = '{mem_to_reg: mem_q.mem_to_reg,
              data_c:     mem_q.data_c,
              reg_write:  mem_q.reg_write,
              dst:        mem_q.dst};
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_alu_src1    = ex_q.alu_src1;
  assign ex_branch      = ex_q.branch;
  assign ex_nbranch     = ex_q.nbranch;
  assign ex_data_c      = ex_q.data_c;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_dst         = ex_q.dst;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_data_c     = mem_q.data_c;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_dst        = mem_q.dst;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_data_c      = wb_q.data_c;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_dst         = wb_q.dst;
  assign stall_count    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Purpose  : Directed self-checking bench for pipe_ctrl_unit. A second
//            instance with a 3-bit stall counter shares all inputs so that
//            counter saturation is reachable in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode_id = 6'h3F;
  logic [5:0] func_id = 6'h00;
  logic [4:0] rs_id = 5'd0, rt_id = 5'd0, rd_id = 5'd0;
  logic       flush_ex = 1'b0;

  wire [1:0]  jmp_id;
  wire        illegal_id, stall_o;
  wire [3:0]  ex_alu_op;
  wire        ex_alu_src, ex_alu_src1, ex_branch, ex_nbranch, ex_data_c, ex_mem_read, ex_reg_write;
  wire [4:0]  ex_dst;
  wire        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_data_c, mem_reg_write;
  wire [4:0]  mem_dst;
  wire        wb_mem_to_reg, wb_data_c, wb_reg_write;
  wire [4:0]  wb_dst;
  wire [15:0] stall_count;

  wire [1:0]  s_jmp_id;
  wire        s_illegal_id, s_stall_o;
  wire [3:0]  s_ex_alu_op;
  wire        s_ex_alu_src, s_ex_alu_src1, s_ex_branch, s_ex_nbranch, s_ex_data_c, s_ex_mem_read, s_ex_reg_write;
  wire [4:0]  s_ex_dst;
  wire        s_mem_mem_read, s_mem_mem_write, s_mem_mem_to_reg, s_mem_data_c, s_mem_reg_write;
  wire [4:0]  s_mem_dst;
  wire        s_wb_mem_to_reg, s_wb_data_c, s_wb_reg_write;
  wire [4:0]  s_wb_dst;
  wire [2:0]  s_stall_count;

  // Packed views: ex = {alu_op, alu_src, src1, branch, nbranch, data_c, mem_read, reg_write, dst}
  wire [15:0] ex_vec  = {ex_alu_op, ex_alu_src, ex_alu_src1, ex_branch, ex_nbranch,
                         ex_data_c, ex_mem_read, ex_reg_write, ex_dst};
  // mem = {mem_read, mem_write, mem_to_reg, data_c, reg_write, dst}
  wire [9:0]  mem_vec = {mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_data_c, mem_reg_write, mem_dst};
  // wb = {mem_to_reg, data_c, reg_write, dst}
  wire [7:0]  wb_vec  = {wb_mem_to_reg, wb_data_c, wb_reg_write, wb_dst};

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .LOADUSE_EN(1'b1), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .func_id(func_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .flush_ex(flush_ex),
    .jmp_id(jmp_id), .illegal_id(illegal_id), .stall_o(stall_o),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_alu_src1(ex_alu_src1),
    .ex_branch(ex_branch), .ex_nbranch(ex_nbranch), .ex_data_c(ex_data_c),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_data_c(mem_data_c), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_data_c(wb_data_c), .wb_reg_write(wb_reg_write),
    .wb_dst(wb_dst), .stall_count(stall_count)
  );

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(4), .LOADUSE_EN(1'b1), .STALL_CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .func_id(func_id),
    .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .flush_ex(flush_ex),
    .jmp_id(s_jmp_id), .illegal_id(s_illegal_id), .stall_o(s_stall_o),
    .ex_alu_op(s_ex_alu_op), .ex_alu_src(s_ex_alu_src), .ex_alu_src1(s_ex_alu_src1),
    .ex_branch(s_ex_branch), .ex_nbranch(s_ex_nbranch), .ex_data_c(s_ex_data_c),
    .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write), .ex_dst(s_ex_dst),
    .mem_mem_read(s_mem_mem_read), .mem_mem_write(s_mem_mem_write), .mem_mem_to_reg(s_mem_mem_to_reg),
    .mem_data_c(s_mem_data_c), .mem_reg_write(s_mem_reg_write), .mem_dst(s_mem_dst),
    .wb_mem_to_reg(s_wb_mem_to_reg), .wb_data_c(s_wb_data_c), .wb_reg_write(s_wb_reg_write),
    .wb_dst(s_wb_dst), .stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    opcode_id = op; func_id = fn; rs_id = rs; rt_id = rt; rd_id = rd;
    #1;
  endtask

  task automatic idle;
    drive(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_ex = 1'b0; idle();
    tick(); tick();
    n_cmp++; if (ex_vec !== 16'h0) begin n_err++; $display("FAIL reset_ex: got %h want 0000", ex_vec); end
    n_cmp++; if (mem_vec !== 10'h0) begin n_err++; $display("FAIL reset_mem: got %h want 000", mem_vec); end
    n_cmp++; if (wb_vec !== 8'h0) begin n_err++; $display("FAIL reset_wb: got %h want 00", wb_vec); end
    n_cmp++; if (stall_count !== 16'h0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got cnt=%h stall=%b want 0/0", stall_count, stall_o); end
    rst = 1'b0;
  endtask

  task automatic test_addi;
    drive(6'b001000, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b1000001, 5'd5}) begin
      n_err++; $display("FAIL addi_ex: got %h want %h", ex_vec, {4'b0000, 7'b1000001, 5'd5}); end
    idle(); tick();
    n_cmp++; if (mem_vec !== {5'b00001, 5'd5}) begin
      n_err++; $display("FAIL addi_mem: got %h want %h", mem_vec, {5'b00001, 5'd5}); end
    tick();
    n_cmp++; if (wb_vec !== {3'b001, 5'd5}) begin
      n_err++; $display("FAIL addi_wb: got %h want %h", wb_vec, {3'b001, 5'd5}); end
  endtask

  task automatic test_load_use;
    drive(6'b010111, 6'h00, 5'd0, 5'd8, 5'd0);
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b1000011, 5'd8}) begin
      n_err++; $display("FAIL lw_ex: got %h want %h", ex_vec, {4'b0000, 7'b1000011, 5'd8}); end
    drive(6'b000000, 6'b100000, 5'd8, 5'd9, 5'd10);
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall_o); end
    tick(); exp_cnt++;
    n_cmp++; if (ex_vec !== 16'h0) begin n_err++; $display("FAIL lu_bubble: got %h want 0000", ex_vec); end
    n_cmp++; if (stall_count !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL lu_count: got %0d want %0d", stall_count, exp_cnt); end
    n_cmp++; if (mem_vec !== {5'b10101, 5'd8}) begin
      n_err++; $display("FAIL lu_mem: got %h want %h", mem_vec, {5'b10101, 5'd8}); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b0000001, 5'd10}) begin
      n_err++; $display("FAIL lu_add_ex: got %h want %h", ex_vec, {4'b0000, 7'b0000001, 5'd10}); end
    // lw to r0 never stalls
    drive(6'b010111, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    drive(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd10);
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_r0: got %b want 0", stall_o); end
    // lw to r8, consumer reads r3/r4: no stall
    drive(6'b010111, 6'h00, 5'd0, 5'd8, 5'd0);
    tick();
    drive(6'b000000, 6'b100000, 5'd3, 5'd4, 5'd10);
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_indep: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b0000001, 5'd10} || stall_count !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL lu_indep_ex: got %h/%0d want %h/%0d", ex_vec, stall_count,
                        {4'b0000, 7'b0000001, 5'd10}, exp_cnt); end
  endtask

  task automatic test_jumps;
    idle(); tick(); tick(); tick();
    drive(6'b000011, 6'h00, 5'd0, 5'd7, 5'd0);
    n_cmp++; if (jmp_id !== 2'b01 || illegal_id !== 1'b0) begin
      n_err++; $display("FAIL jal_jmp: got %b/%b want 01/0", jmp_id, illegal_id); end
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b0000101, 5'd31}) begin
      n_err++; $display("FAIL jal_ex: got %h want %h", ex_vec, {4'b0000, 7'b0000101, 5'd31}); end
    idle(); tick(); tick();
    n_cmp++; if (wb_vec !== {3'b011, 5'd31}) begin
      n_err++; $display("FAIL jal_wb: got %h want %h", wb_vec, {3'b011, 5'd31}); end
    drive(6'b000000, 6'b010000, 5'd3, 5'd0, 5'd0);
    n_cmp++; if (jmp_id !== 2'b10) begin n_err++; $display("FAIL jr_jmp: got %b want 10", jmp_id); end
    tick();
    n_cmp++; if (ex_vec !== 16'h0) begin n_err++; $display("FAIL jr_ex: got %h want 0000", ex_vec); end
    drive(6'b000000, 6'b010001, 5'd3, 5'd0, 5'd6);
    n_cmp++; if (jmp_id !== 2'b10) begin n_err++; $display("FAIL jalr_jmp: got %b want 10", jmp_id); end
    tick();
    n_cmp++; if (ex_vec !== {4'b0000, 7'b0000101, 5'd31} || mem_vec !== 10'h0) begin
      n_err++; $display("FAIL jalr_ex: got %h/%h want %h/000", ex_vec, mem_vec, {4'b0000, 7'b0000101, 5'd31}); end
    idle(); tick();
    n_cmp++; if (wb_vec !== 8'h0) begin n_err++; $display("FAIL jr_wb: got %h want 00", wb_vec); end
  endtask

  task automatic test_flush;
    drive(6'b010111, 6'h00, 5'd0, 5'd8, 5'd0);
    tick();
    drive(6'b000000, 6'b100000, 5'd8, 5'd9, 5'd10);
    flush_ex = 1'b1; #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall_o); end
    tick();
    n_cmp++; if (ex_vec !== 16'h0 || stall_count !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL flush_ex: got %h/%0d want 0000/%0d", ex_vec, stall_count, exp_cnt); end
    drive(6'b001000, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    n_cmp++; if (ex_vec !== 16'h0) begin n_err++; $display("FAIL flush_plain: got %h want 0000", ex_vec); end
    flush_ex = 1'b0;
  endtask

  task automatic test_illegal;
    drive(6'b001000, 6'h00, 5'd1, 5'd5, 5'd0);
    tick();
    drive(6'b111111, 6'h00, 5'd9, 5'd9, 5'd9);
    n_cmp++; if (illegal_id !== 1'b1 || jmp_id !== 2'b00) begin
      n_err++; $display("FAIL ill_flag: got %b/%b want 1/00", illegal_id, jmp_id); end
    tick();
    n_cmp++; if (ex_vec !== 16'h0 || mem_vec !== {5'b00001, 5'd5}) begin
      n_err++; $display("FAIL ill_ex: got %h/%h want 0000/%h", ex_vec, mem_vec, {5'b00001, 5'd5}); end
    tick();
    n_cmp++; if (mem_vec !== 10'h0 || wb_vec !== {3'b001, 5'd5}) begin
      n_err++; $display("FAIL ill_mem: got %h/%h want 000/%h", mem_vec, wb_vec, {3'b001, 5'd5}); end
    tick();
    n_cmp++; if (wb_vec !== 8'h0) begin n_err++; $display("FAIL ill_wb: got %h want 00", wb_vec); end
  endtask

  task automatic test_decode;
    logic [5:0]  t_op  [13] = '{6'b001010, 6'b001101, 6'b001111, 6'b000111, 6'b000001, 6'b101011,
                                6'b000100, 6'b000101, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000};
    logic [5:0]  t_fn  [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'b001011, 6'b001101, 6'b001000, 6'b100010, 6'b001100};
    logic [15:0] t_exp [13] = '{{4'b0101, 7'b1000001, 5'd3},
                                {4'b0100, 7'b1000001, 5'd3},
                                {4'b0111, 7'b1000001, 5'd3},
                                {4'b1111, 7'b1000001, 5'd3},
                                {4'b0011, 7'b1000001, 5'd3},
                                {4'b0000, 7'b1000000, 5'd3},
                                {4'b0001, 7'b0010000, 5'd3},
                                {4'b0001, 7'b0001000, 5'd3},
                                {4'b1000, 7'b0000001, 5'd12},
                                {4'b1010, 7'b0000001, 5'd12},
                                {4'b1000, 7'b0100001, 5'd12},
                                {4'b0010, 7'b0000001, 5'd12},
                                {4'b1001, 7'b0000001, 5'd12}};
    for (int i = 0; i < 13; i++) begin
      drive(t_op[i], t_fn[i], 5'd0, 5'd3, 5'd12);
      tick();
      n_cmp++; if (ex_vec !== t_exp[i]) begin
        n_err++; $display("FAIL decode_%0d: got %h want %h", i, ex_vec, t_exp[i]); end
    end
    // sw reaches EX/MEM with mem_write only
    idle(); tick(); tick();
    drive(6'b101011, 6'h00, 5'd0, 5'd3, 5'd0);
    tick(); idle(); tick();
    n_cmp++; if (mem_vec !== {5'b01000, 5'd3}) begin
      n_err++; $display("FAIL sw_mem: got %h want %h", mem_vec, {5'b01000, 5'd3}); end
  endtask

  task automatic test_saturation;
    idle(); tick();
    drive(6'b010111, 6'h00, 5'd8, 5'd8, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL sat_stall_%0d: got %b want 1", i, stall_o); end
      tick(); exp_cnt++;
      tick();
    end
    n_cmp++; if (stall_count !== 16'(exp_cnt)) begin
      n_err++; $display("FAIL sat_cnt16: got %0d want %0d", stall_count, exp_cnt); end
    n_cmp++; if (s_stall_count !== 3'd7) begin
      n_err++; $display("FAIL sat_cnt3: got %0d want 7", s_stall_count); end
  endtask

  task automatic test_reset_mid_stall;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b want 1", stall_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (ex_vec !== 16'h0 || mem_vec !== 10'h0 || wb_vec !== 8'h0) begin
      n_err++; $display("FAIL rst_mid_regs: got %h/%h/%h want 0", ex_vec, mem_vec, wb_vec); end
    n_cmp++; if (stall_count !== 16'h0 || s_stall_count !== 3'd0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_stall: got %0d/%0d/%b want 0/0/0", stall_count, s_stall_count, stall_o); end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_jumps();
    test_flush();
    test_illegal();
    test_decode();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
